maquina_estados: RTL and testbench
==================================

// Module: maquina_estados
// PURPOSE
// - Controller FSM for a 4-floor elevator (floors 0..3).
// - Latches floor-call buttons, moves the car one floor at a time in SCAN order,
//   opens the doors at each requested floor, and reports floor, action and door state.
// - Top-level control block; outputs drive the floor display, motor and door drivers.
// PARAMETERS
// - T_VIAJE   4  clock cycles (while en=1) to travel between adjacent floors, >=1
// - T_PUERTA  3  clock cycles (while en=1) the doors stay open, >=1
// PORTS
// - clk         in   1  single system clock, rising edge
// - rst         in   1  asynchronous, active-high reset
// - en          in   1  clock enable; 0 freezes all state, counters and outputs
// - boton_pres  in   4  floor-call buttons, bit i = call to floor i, level-sampled
// - piso        out  2  current floor of the car, 0..3
// - accion      out  2  00 REPOSO, 01 SUBIENDO, 10 BAJANDO, 11 PUERTA
// - puertas     out  1  1 = doors open
// BEHAVIOUR
// - All outputs registered. Reset: piso=0, accion=00, puertas=0, requests=0,
//   timer=0, dir=up, state REPOSO. Reset mid-trip abandons the trip; car reports floor 0.
// - Request register req[3:0]:
//   - When en=1: req <= (req | boton_pres) & ~clr.
//   - clr = bit for piso when state is PUERTA.
//   - A press at the current floor while doors are open is absorbed, not re-queued.
// - "Ahead" means any req bit above piso (dir=up) or below piso (dir=down).
// - When en=0, nothing updates.
// - REPOSO (accion=00, puertas=0):
//   - req[piso] -> PUERTA, timer=T_PUERTA.
//   - Else any req above -> SUBIENDO, dir=up.
//   - Else any req below -> BAJANDO, dir=down.
//   - Else stay in REPOSO.
// - SUBIENDO / BAJANDO (accion=01/10, puertas=0):
//   - timer counts T_VIAJE cycles.
//   - At expiry, piso +1 / -1 (exactly one step).
//   - Then: req[new piso] -> PUERTA; else req ahead -> keep moving, timer reloads;
//     else -> REPOSO.
//   - Car never moves with no request ahead, so piso never wraps past 3 or below 0.
// - PUERTA (accion=11, puertas=1):
//   - Stays T_PUERTA cycles, clearing req[piso] each cycle.
//   - At expiry: req ahead -> continue in dir; else req behind -> reverse dir and
//     move; else -> REPOSO.
// - Latency:
//   - Press sampled at edge n; REPOSO acts on it at edge n+1.
//   - Movement begins that edge.
// - Simultaneous requests above and below from REPOSO: up has priority.
// - Multiple presses in one cycle are all latched. Held buttons re-set bits after
//   service, except at the floor whose doors are open.
// TESTING
// - Reset held 1, en=1 -> piso=0, accion=00, puertas=0 regardless of boton_pres.
// - Idle at 0, press bit2 one cycle -> accion=01; piso 1 after 4 cycles, 2 after 8;
//   then accion=11, puertas=1 for 3 cycles; then accion=00 at floor 2.
// - At 2 idle, press bits 3 and 0 together -> go up to 3, doors 3 cycles,
//   then reverse: accion=10 down to 0, doors, idle.
// - Press current floor while idle -> puertas=1 next edge for 3 cycles, no movement;
//   re-press while open -> no extra cycle.
// - en=0 mid-trip for 10 cycles -> piso/accion/timer frozen; resumes where it stopped.
// - Assert rst while SUBIENDO between 1 and 2 -> immediate piso=0, accion=00,
//   requests cleared.

Source files
------------

// File: rtl/maquina_estados.sv
// Four-floor elevator controller: latches floor calls, serves them in SCAN order
// and drives the floor display, motor direction and door outputs.
module maquina_estados #(
   parameter int T_VIAJE  = 4,
   parameter int T_PUERTA = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] boton_pres,
   output logic [1:0] piso,
   output logic [1:0] accion,
   output logic       puertas
);

   typedef enum logic [1:0] {
      REPOSO   = 2'b00,
      SUBIENDO = 2'b01,
      BAJANDO  = 2'b10,
      PUERTA   = 2'b11
   } estado_t;

   localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] T_VIAJE_L  = TW'(T_VIAJE);
   localparam logic [TW-1:0] T_PUERTA_L = TW'(T_PUERTA);

   estado_t       estado_q, estado_d;
   logic [1:0]    piso_q, piso_d;
   logic          dir_q, dir_d;       // 1 = up, 0 = down
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    req_q, req_d;
   logic          puertas_q, puertas_d;

   logic [3:0] clr;
   logic [1:0] piso_llegada;
   logic       hay_arriba, hay_abajo, arr_arriba, arr_abajo, timer_fin;

   function automatic logic [3:0] mask_arriba(input logic [1:0] p);
      return 4'b1110 << p;
   endfunction

   function automatic logic [3:0] mask_abajo(input logic [1:0] p);
      return (4'b0001 << p) - 4'd1;
   endfunction

   // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      estado_d  = estado_q;
      piso_d    = piso_q;
      dir_d     = dir_q;
      timer_d   = timer_q;
      clr       = (estado_q == PUERTA) ? (4'b0001 << piso_q) : 4'b0000;
      req_d     = (req_q | boton_pres) & ~clr;

      hay_arriba   = |(req_q & mask_arriba(piso_q));
      hay_abajo    = |(req_q & mask_abajo(piso_q));
      piso_llegada = (estado_q == SUBIENDO) ? piso_q + 2'd1 : piso_q - 2'd1;
      arr_arriba   = |(req_q & mask_arriba(piso_llegada));
      arr_abajo    = |(req_q & mask_abajo(piso_llegada));
      timer_fin    = (timer_q <= TW'(1));

      unique case (estado_q)
         REPOSO: begin
            if (req_q[piso_q]) begin
               estado_d = PUERTA;
               timer_d  = T_PUERTA_L;
            end else if (hay_arriba) begin
               estado_d = SUBIENDO;
               dir_d    = 1'b1;
               timer_d  = T_VIAJE_L;
            end else if (hay_abajo) begin
               estado_d = BAJANDO;
               dir_d    = 1'b0;
               timer_d  = T_VIAJE_L;
            end
         end

         SUBIENDO, BAJANDO: begin
            if (!timer_fin) begin
               timer_d = timer_q - TW'(1);
            end else begin
               piso_d = piso_llegada;
               if (req_q[piso_llegada]) begin
                  estado_d = PUERTA;
                  timer_d  = T_PUERTA_L;
               end else if (dir_q ? arr_arriba : arr_abajo) begin
                  timer_d = T_VIAJE_L;
               end else begin
                  estado_d = REPOSO;
                  timer_d  = '0;
               end
            end
         end

         PUERTA: begin
            if (!timer_fin) begin
               timer_d = timer_q - TW'(1);
            end else if (dir_q ? hay_arriba : hay_abajo) begin
               estado_d = dir_q ? SUBIENDO : BAJANDO;
               timer_d  = T_VIAJE_L;
            end else if (dir_q ? hay_abajo : hay_arriba) begin
               // Nothing left ahead but calls behind: reverse and leave immediately.
               dir_d    = ~dir_q;
               estado_d = dir_q ? BAJANDO : SUBIENDO;
               timer_d  = T_VIAJE_L;
            end else begin
               estado_d = REPOSO;
               timer_d  = '0;
            end
         end

         default: estado_d = REPOSO;
      endcase

      puertas_d = (estado_d == PUERTA);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q  <= REPOSO;
         piso_q    <= 2'd0;
         dir_q     <= 1'b1;
         timer_q   <= '0;
         req_q     <= 4'b0000;
         puertas_q <= 1'b0;
      end else if (en) begin
         estado_q  <= estado_d;
         piso_q    <= piso_d;
         dir_q     <= dir_d;
         timer_q   <= timer_d;
         req_q     <= req_d;
         puertas_q <= puertas_d;
      end
   end

   assign piso    = piso_q;
   assign accion  = estado_q;
   assign puertas = puertas_q;

endmodule

// File: tb/tb_maquina_estados.sv
// Self-checking bench for maquina_estados: directed scenarios plus random calls,
// compared cycle by cycle against a behavioural elevator model through a scoreboard.
module tb_maquina_estados;

   localparam int T_VIAJE  = 4;
   localparam int T_PUERTA = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [3:0] boton_pres = 4'b0000;
   logic [1:0] piso;
   logic [1:0] accion;
   logic       puertas;

   maquina_estados #(.T_VIAJE(T_VIAJE), .T_PUERTA(T_PUERTA)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .boton_pres (boton_pres),
      .piso       (piso),
      .accion     (accion),
      .puertas    (puertas)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] piso;
      logic [1:0] accion;
      logic       puertas;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Behavioural model: position, remaining travel/door cycles, direction, pending calls.
   int       m_piso, m_dir, m_travel, m_door;
   bit [3:0] m_req;

   function automatic bit any_side(input bit [3:0] r, input int p, input int d);
      for (int i = 0; i < 4; i++)
         if (r[i] && (i - p) * d > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_piso = 0; m_dir = 1; m_travel = 0; m_door = 0; m_req = '0;
   endtask

   task automatic model_step(input bit [3:0] b);
      bit [3:0] old_req;
      bit [3:0] new_req;
      old_req = m_req;
      new_req = old_req | b;
      if (m_door > 0) new_req[m_piso] = 1'b0;

      if (m_door > 0) begin
         m_door--;
         if (m_door == 0) begin
            if (any_side(old_req, m_piso, m_dir)) begin
               m_travel = T_VIAJE;
            end else if (any_side(old_req, m_piso, -m_dir)) begin
               m_dir    = -m_dir;
               m_travel = T_VIAJE;
            end
         end
      end else if (m_travel > 0) begin
         m_travel--;
         if (m_travel == 0) begin
            m_piso += m_dir;
            if (old_req[m_piso])                    m_door   = T_PUERTA;
            else if (any_side(old_req, m_piso, m_dir)) m_travel = T_VIAJE;
         end
      end else begin
         if (old_req[m_piso]) begin
            m_door = T_PUERTA;
         end else if (any_side(old_req, m_piso, 1)) begin
            m_dir = 1; m_travel = T_VIAJE;
         end else if (any_side(old_req, m_piso, -1)) begin
            m_dir = -1; m_travel = T_VIAJE;
         end
      end
      m_req = new_req;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.piso = 2'(m_piso);
      if (m_door > 0) begin
         e.accion = 2'b11; e.puertas = 1'b1;
      end else if (m_travel > 0) begin
         e.accion = (m_dir > 0) ? 2'b01 : 2'b10; e.puertas = 1'b0;
      end else begin
         e.accion = 2'b00; e.puertas = 1'b0;
      end
      return e;
   endfunction

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic cyc(input logic r, input logic e, input logic [3:0] b);
      @(negedge clk);
      rst = r; en = e; boton_pres = b;
      if (r)      model_reset();
      else if (e) model_step(b);
      sb.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'b0000);
   endtask

   // Monitor: outputs are presented every cycle, so pop and compare after each edge.
   initial begin
      exp_t exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_cmp++;
            if (piso !== exp_v.piso || accion !== exp_v.accion || puertas !== exp_v.puertas) begin
               n_err++;
               $display("FAIL outputs t=%0t: got piso=%0d accion=%b puertas=%b, want piso=%0d accion=%b puertas=%b",
                        $time, piso, accion, puertas, exp_v.piso, exp_v.accion, exp_v.puertas);
            end
         end
      end
   end

   initial begin
      logic [3:0] b;
      model_reset();

      // Reset held with buttons pressed.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'b1111);

      // Idle at 0, call floor 2.
      cyc(1'b0, 1'b1, 4'b0100);
      idle(20);

      // At 2, calls to 3 and 0 together: up first, then reverse.
      cyc(1'b0, 1'b1, 4'b1001);
      idle(40);

      // Call current floor (0), then re-press while doors are open.
      cyc(1'b0, 1'b1, 4'b0001);
      idle(2);
      cyc(1'b0, 1'b1, 4'b0001);
      idle(8);

      // Freeze mid-trip for 10 cycles.
      cyc(1'b0, 1'b1, 4'b1000);
      idle(3);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 4'b0000);
      idle(30);

      // Reset while travelling between floors.
      cyc(1'b1, 1'b1, 4'b0000);
      idle(2);
      cyc(1'b0, 1'b1, 4'b0100);
      idle(6);
      cyc(1'b1, 1'b1, 4'b0000);
      idle(5);

      // Random calls, holds, enable gaps and occasional resets.
      b = 4'b0000;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0)      b = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 2) != 0) b = 4'b0000;
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0), b);
      end
      idle(40);

      @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
